// File: rtl/adc_conv_arbiter_pkg.sv
// Shared definitions for the ADC conversion arbiter and related converter-side blocks.
// Holds the state encoding, the soc/eoc protocol levels, and a small index-wrap helper.
package adc_conv_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_START    = 3'd3,
        ST_CONV     = 3'd4,
        ST_RELEASE  = 3'd5
    } arb_state_t;

    // Converter handshake levels
    localparam logic SOC_ASSERT = 1'b1;
    localparam logic SOC_IDLE   = 1'b0;
    localparam logic EOC_DONE   = 1'b1;
    localparam logic EOC_BUSY   = 1'b0;

    // Wrap an index sum back into 0..n-1; sum is always below 2*n here.
    function automatic int unsigned wrap_index(input int unsigned sum, input int unsigned n);
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/adc_conv_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: picks the first pending requester
// strictly after rr_ptr, wrapping modulo N_REQ.
module adc_conv_arbiter_rr_pick
    import adc_conv_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IW-1:0]    rr_ptr,
    output logic [IW-1:0]    grant,
    output logic             valid
);

    logic [IW-1:0]    cand [N_REQ];
    logic [N_REQ-1:0] hit;

    // Candidate gi is the requester sitting gi+1 places after the pointer
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        assign cand[gi] = IW'(wrap_index(32'(rr_ptr) + 32'(gi) + 32'd1, 32'(N_REQ)));
        assign hit[gi]  = pending[cand[gi]];
    end

    // Nearest candidate after the pointer wins
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                grant = cand[k];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_conv_arbiter.sv
// Shares one SOC/EOC converter among N_REQ requesters: round-robin grant,
// mux settle delay, soc/eoc handshake with timeout, 4-phase req/ack result return.
module adc_conv_arbiter
    import adc_conv_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                     clock,
    input  logic                     reset_,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         ack,
    output logic [DW-1:0]            result,
    output logic                     err,
    output logic                     soc,
    input  logic                     eoc,
    input  logic [DW-1:0]            x,
    output logic [$clog2(N_REQ)-1:0] sel,
    output logic                     busy
);

    localparam int IW   = $clog2(N_REQ);
    localparam int CMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
    localparam logic [IW-1:0] RR_RESET    = IW'(N_REQ - 1);

    arb_state_t       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [IW-1:0]    sel_reg;
    logic [IW-1:0]    rr_reg;
    logic [N_REQ-1:0] ack_reg;
    logic [DW-1:0]    result_reg;
    logic             err_reg;
    logic             soc_reg;
    logic             busy_reg;

    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [CW-1:0]    cnt_inc;
    logic             timed_out;

    // Saturating increment: the counter never wraps back to zero
    assign cnt_inc   = (cnt_reg == {CW{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
    assign timed_out = (cnt_reg >= TIMEOUT_CNT);

    adc_conv_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .pending (req & ~ack_reg),
        .rr_ptr  (rr_reg),
        .grant   (pick_idx),
        .valid   (pick_valid)
    );

    // Arbitration FSM and converter handshake; every output is a flop
    always_ff @(posedge clock) begin
        if (reset_) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            sel_reg    <= '0;
            rr_reg     <= RR_RESET;
            ack_reg    <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
            soc_reg    <= SOC_IDLE;
            busy_reg   <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        sel_reg   <= pick_idx;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg >= SETTLE_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT_RDY;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                ST_WAIT_RDY, ST_START, ST_CONV: begin
                    if (state_reg == ST_WAIT_RDY && eoc == EOC_DONE) begin
                        soc_reg   <= SOC_ASSERT;
                        cnt_reg   <= '0;
                        state_reg <= ST_START;
                    end else if (state_reg == ST_START && eoc == EOC_BUSY) begin
                        soc_reg   <= SOC_IDLE;
                        cnt_reg   <= '0;
                        state_reg <= ST_CONV;
                    end else if (state_reg == ST_CONV && eoc == EOC_DONE) begin
                        result_reg <= x;
                        ack_reg    <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_reg;
                        cnt_reg    <= '0;
                        state_reg  <= ST_RELEASE;
                    end else if (timed_out) begin
                        // Abandon this requester; it is re-served on a later round
                        soc_reg   <= SOC_IDLE;
                        err_reg   <= 1'b1;
                        rr_reg    <= sel_reg;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (!req[sel_reg]) begin
                        ack_reg   <= '0;
                        rr_reg    <= sel_reg;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    soc_reg   <= SOC_IDLE;
                    ack_reg   <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack    = ack_reg;
    assign result = result_reg;
    assign err    = err_reg;
    assign soc    = soc_reg;
    assign sel    = sel_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_adc_conv_arbiter.sv
// Self-checking bench for adc_conv_arbiter: behavioural converter model,
// table-driven arbitration vectors and hand-written multi-cycle sequences.
module tb_adc_conv_arbiter;

    localparam int N_REQ    = 4;
    localparam int DW       = 8;
    localparam int SETTLE   = 3;
    localparam int TIMEOUT  = 255;
    localparam int CONV_LEN = 5;
    localparam int BUDGET   = 600;

    logic             clock  = 1'b0;
    logic             reset_ = 1'b1;
    logic [N_REQ-1:0] req    = '0;
    logic [N_REQ-1:0] ack;
    logic [DW-1:0]    result;
    logic             err;
    logic             soc;
    logic             eoc;
    logic [DW-1:0]    x;
    logic [1:0]       sel;
    logic             busy;

    int checks = 0;
    int errors = 0;

    adc_conv_arbiter #(
        .N_REQ   (N_REQ),
        .DW      (DW),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .req    (req),
        .ack    (ack),
        .result (result),
        .err    (err),
        .soc    (soc),
        .eoc    (eoc),
        .x      (x),
        .sel    (sel),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Converter model controls (written only by the main sequence)
    logic [DW-1:0] conv_data  = '0;
    bit            stuck      = 1'b0;
    int            busy_until = 0;

    // Converter model: eoc drops the cycle soc is seen, stays low CONV_LEN cycles,
    // then rises with conv_data on x.
    initial begin
        int left;
        left = 0;
        eoc  = 1'b1;
        x    = '0;
        forever begin
            @(posedge clock);
            #1;
            if (cyc < busy_until) begin
                eoc = 1'b0;
            end else if (left > 0) begin
                left--;
                if (left == 0) begin
                    eoc = 1'b1;
                    x   = conv_data;
                end
            end else if (!stuck && soc && eoc) begin
                eoc  = 1'b0;
                left = CONV_LEN;
            end else begin
                eoc = 1'b1;
            end
        end
    end

    // Event monitor: timestamps edges of interest, counts err cycles, flags multi-ack
    int t_soc_rise = -1, t_soc_fall = -1, t_eoc_rise = -1, t_ack_rise = -1;
    int t_sel_change = -1, t_err = -1, err_count = 0;
    bit multi_ack = 1'b0;
    logic soc_q = 1'b0, eoc_q = 1'b1;
    logic [N_REQ-1:0] ack_q = '0;
    logic [1:0] sel_q = '0;

    always @(negedge clock) begin
        if (soc === 1'b1 && soc_q === 1'b0) t_soc_rise = cyc;
        if (soc === 1'b0 && soc_q === 1'b1) t_soc_fall = cyc;
        if (eoc === 1'b1 && eoc_q === 1'b0) t_eoc_rise = cyc;
        if (ack !== '0 && ack_q === '0) t_ack_rise = cyc;
        if (sel !== sel_q && !$isunknown(sel)) t_sel_change = cyc;
        if (err === 1'b1) begin
            err_count++;
            t_err = cyc;
        end
        if (!$isunknown(ack) && !$onehot0(ack)) multi_ack = 1'b1;
        soc_q = soc;
        eoc_q = eoc;
        ack_q = ack;
        sel_q = sel;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (ack === '0 && n < BUDGET) begin
            tick();
            n++;
        end
        checks++;
        if (ack === '0) begin
            errors++;
            $display("FAIL %s: ack not seen, got 0x%0h after %0d cycles", name, ack, n);
        end
    endtask

    task automatic wait_soc_rise(input string name, input int mark);
        int n;
        n = 0;
        while (t_soc_rise <= mark && n < BUDGET) begin
            tick();
            n++;
        end
        checks++;
        if (t_soc_rise <= mark) begin
            errors++;
            $display("FAIL %s: soc never rose, got soc=%0b after %0d cycles", name, soc, n);
        end
    endtask

    task automatic wait_soc_fall(input string name, input int mark);
        int n;
        n = 0;
        while (t_soc_fall <= mark && n < BUDGET) begin
            tick();
            n++;
        end
        checks++;
        if (t_soc_fall <= mark) begin
            errors++;
            $display("FAIL %s: soc never fell, got soc=%0b after %0d cycles", name, soc, n);
        end
    endtask

    task automatic wait_err(input string name, input int base);
        int n;
        n = 0;
        while (err_count <= base && n < BUDGET) begin
            tick();
            n++;
        end
        checks++;
        if (err_count <= base) begin
            errors++;
            $display("FAIL %s: no err pulse, got count %0d after %0d cycles", name, err_count, n);
        end
    endtask

    task automatic do_reset();
        reset_ = 1'b1;
        tick();
        tick();
        reset_ = 1'b0;
    endtask

    typedef struct {
        logic [N_REQ-1:0] req;
        logic [DW-1:0]    data;
        int               exp_idx;
    } vec_t;

    vec_t vecs [9];
    logic [N_REQ-1:0] exp_ack;
    int mark;
    int err_base;

    initial begin
        // Arbitration vectors, applied from reset (rr pointer starts at N_REQ-1)
        vecs[0] = '{4'b1111, 8'h11, 0};
        vecs[1] = '{4'b1111, 8'h22, 1};
        vecs[2] = '{4'b1111, 8'h33, 2};
        vecs[3] = '{4'b1111, 8'h44, 3};
        vecs[4] = '{4'b1111, 8'h55, 0};
        vecs[5] = '{4'b1010, 8'h66, 1};
        vecs[6] = '{4'b1001, 8'h77, 3};
        vecs[7] = '{4'b0110, 8'h88, 1};
        vecs[8] = '{4'b0001, 8'h99, 0};

        // Reset state
        do_reset();
        check("rst_soc", 32'(soc), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_result", 32'(result), 0);
        check("rst_err", 32'(err), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_busy", 32'(busy), 0);

        // Single request on channel 2
        conv_data = 8'hA5;
        mark = cyc;
        req = 4'b0100;
        wait_soc_rise("t1_soc_rise", mark);
        check("t1_sel_at_soc", 32'(sel), 2);
        check("t1_sel_min_settle", 32'((t_soc_rise - t_sel_change) >= SETTLE), 1);
        check("t1_soc_latency", 32'(t_soc_rise - t_sel_change), SETTLE + 1);
        wait_ack("t1_wait_ack");
        check("t1_ack", 32'(ack), 32'h4);
        check("t1_result", 32'(result), 32'hA5);
        check("t1_soc_fall", 32'(t_soc_fall - t_soc_rise), 1);
        check("t1_ack_latency", 32'(t_ack_rise - t_eoc_rise), 1);
        repeat (3) tick();
        check("t1_ack_hold", 32'(ack), 32'h4);
        check("t1_result_hold", 32'(result), 32'hA5);
        req = 4'b0000;
        tick();
        check("t1_ack_release", 32'(ack), 0);
        check("t1_busy_release", 32'(busy), 0);

        // Round-robin vectors from a fresh reset
        do_reset();
        for (int i = 0; i < 9; i++) begin
            conv_data = vecs[i].data;
            req = vecs[i].req;
            wait_ack($sformatf("t2_wait_ack_%0d", i));
            exp_ack = 4'b0001 << vecs[i].exp_idx;
            check($sformatf("t2_ack_%0d", i), 32'(ack), 32'(exp_ack));
            check($sformatf("t2_sel_%0d", i), 32'(sel), 32'(vecs[i].exp_idx));
            check($sformatf("t2_result_%0d", i), 32'(result), 32'(vecs[i].data));
            req = vecs[i].req & ~exp_ack;
            tick();
            check($sformatf("t2_release_%0d", i), 32'(ack), 0);
        end
        req = 4'b0000;
        tick();

        // Converter busy when the grant reaches WAIT_RDY
        conv_data = 8'hC3;
        busy_until = cyc + 14;
        mark = cyc;
        req = 4'b0100;
        wait_soc_rise("t3_soc_rise", mark);
        check("t3_soc_after_busy", 32'(t_soc_rise > busy_until), 1);
        check("t3_soc_follows_eoc", 32'(t_soc_rise - t_eoc_rise), 1);
        wait_ack("t3_wait_ack");
        check("t3_ack", 32'(ack), 32'h4);
        check("t3_result", 32'(result), 32'hC3);
        req = 4'b0000;
        tick();

        // Converter stuck idle after soc: timeout, then next requester in rotation
        stuck = 1'b1;
        err_base = err_count;
        mark = cyc;
        req = 4'b1010;
        wait_soc_rise("t4_soc_rise", mark);
        check("t4_sel", 32'(sel), 3);
        wait_err("t4_wait_err", err_base);
        check_range("t4_timeout_len", t_err - t_soc_rise, TIMEOUT, TIMEOUT + 2);
        check("t4_soc_at_err", 32'(soc), 0);
        check("t4_ack_at_err", 32'(ack), 0);
        check("t4_busy_at_err", 32'(busy), 0);
        stuck = 1'b0;
        conv_data = 8'h5A;
        repeat (2) tick();
        check("t4_err_single", 32'(err_count - err_base), 1);
        wait_ack("t4_wait_ack_next");
        check("t4_next_ack", 32'(ack), 32'h2);
        check("t4_next_sel", 32'(sel), 1);
        check("t4_next_result", 32'(result), 32'h5A);
        req = 4'b0000;
        tick();

        // Reset while converting
        conv_data = 8'hE7;
        mark = cyc;
        req = 4'b0001;
        wait_soc_fall("t5_soc_fall", mark);
        check("t5_busy_in_conv", 32'(busy), 1);
        reset_ = 1'b1;
        req = 4'b0000;
        tick();
        reset_ = 1'b0;
        check("t5_soc", 32'(soc), 0);
        check("t5_ack", 32'(ack), 0);
        check("t5_result", 32'(result), 0);
        check("t5_busy", 32'(busy), 0);
        conv_data = 8'h3C;
        req = 4'b1111;
        wait_ack("t5_wait_ack");
        check("t5_rr_restart", 32'(ack), 32'h1);
        check("t5_new_result", 32'(result), 32'h3C);
        req = 4'b0000;
        tick();

        // Requester drops req before ack
        conv_data = 8'h96;
        mark = cyc;
        req = 4'b0010;
        wait_soc_fall("t6_soc_fall", mark);
        req = 4'b0000;
        wait_ack("t6_wait_ack");
        check("t6_ack", 32'(ack), 32'h2);
        check("t6_result", 32'(result), 32'h96);
        tick();
        check("t6_ack_pulse", 32'(ack), 0);
        check("t6_busy", 32'(busy), 0);
        conv_data = 8'h69;
        req = 4'b0100;
        wait_ack("t6_wait_ack_next");
        check("t6_next_ack", 32'(ack), 32'h4);
        check("t6_next_result", 32'(result), 32'h69);
        req = 4'b0000;
        tick();
        check("t6_next_release", 32'(ack), 0);

        // Whole-run invariants
        check("multi_ack", 32'(multi_ack), 0);
        check("err_total", 32'(err_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
